// File: rtl/l2_tag_array.sv
// N-way L2 tag/valid/dirty array with registered lookup, per-way write forwarding
// and a one-set-per-cycle invalidation sweep after reset or flush.
module l2_tag_array #(
  parameter int s_index = 3,
  parameter int s_tag = 23,
  parameter int ways = 4,
  localparam int s_way = $clog2(ways),
  localparam int num_sets = 2 ** s_index
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    ready,
  input  logic                    read,
  input  logic [s_index-1:0]      rindex,
  input  logic [s_tag-1:0]        rtag,
  input  logic                    load,
  input  logic [s_index-1:0]      windex,
  input  logic [s_way-1:0]        wway,
  input  logic [s_tag-1:0]        wtag,
  input  logic                    wvalid,
  input  logic                    wdirty,
  output logic                    hit,
  output logic [s_way-1:0]        hit_way,
  output logic                    multi_hit,
  output logic [ways*s_tag-1:0]   tag_out,
  output logic [ways-1:0]         valid_out,
  output logic [ways-1:0]         dirty_out
);

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t               state_r, state_next_s;
  logic [s_index-1:0]   sweep_idx_r, sweep_idx_next_s;

  logic [s_tag-1:0]     tag_mem_r   [num_sets][ways];
  logic [ways-1:0]      valid_mem_r [num_sets];
  logic [ways-1:0]      dirty_mem_r [num_sets];

  logic                 sweep_last_s;
  logic                 sweep_clr_s;
  logic                 accept_s;
  logic                 do_read_s;
  logic                 do_load_s;

  logic [ways*s_tag-1:0] look_tag_s;
  logic [ways-1:0]       look_valid_s;
  logic [ways-1:0]       look_dirty_s;
  logic [ways-1:0]       match_s;
  logic [s_way-1:0]      hit_way_s;
  logic [s_way:0]        match_cnt_s;

  assign ready        = (state_r == IDLE);
  assign sweep_last_s = (sweep_idx_r == s_index'(num_sets - 1));
  assign sweep_clr_s  = !rst && (state_r == SWEEP);
  // Flush takes priority: any read or load in the flush cycle is dropped.
  assign accept_s     = !rst && (state_r == IDLE) && !flush;
  assign do_read_s    = accept_s && read;
  assign do_load_s    = accept_s && load;

  // Next-state and sweep counter logic.
  always_comb begin
    state_next_s     = state_r;
    sweep_idx_next_s = sweep_idx_r;
    case (state_r)
      SWEEP: begin
        sweep_idx_next_s = sweep_idx_r + s_index'(1);
        if (sweep_last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SWEEP;
        end
      end
      IDLE: begin
        if (flush) begin
          state_next_s     = SWEEP;
          sweep_idx_next_s = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s     = SWEEP;
        sweep_idx_next_s = '0;
      end
    endcase
  end

  // State register; reset restarts the sweep from set 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= SWEEP;
      sweep_idx_r <= '0;
    end else begin
      state_r     <= state_next_s;
      sweep_idx_r <= sweep_idx_next_s;
    end
  end

  // Metadata storage: sweep clears valid/dirty only; tags are left as-is.
  always_ff @(posedge clk) begin
    if (sweep_clr_s) begin
      valid_mem_r[sweep_idx_r] <= '0;
      dirty_mem_r[sweep_idx_r] <= '0;
    end else if (do_load_s) begin
      tag_mem_r[windex][wway]   <= wtag;
      valid_mem_r[windex][wway] <= wvalid;
      dirty_mem_r[windex][wway] <= wdirty;
    end
  end

  // Lookup of set rindex with same-cycle forwarding of the way being written.
  always_comb begin
    look_tag_s   = '0;
    look_valid_s = '0;
    look_dirty_s = '0;
    match_s      = '0;
    hit_way_s    = '0;
    match_cnt_s  = '0;
    for (int w = 0; w < ways; w++) begin
      if (load && read && (windex == rindex) && (wway == s_way'(w))) begin
        look_tag_s[w*s_tag +: s_tag] = wtag;
        look_valid_s[w]              = wvalid;
        look_dirty_s[w]              = wdirty;
      end else begin
        look_tag_s[w*s_tag +: s_tag] = tag_mem_r[rindex][w];
        look_valid_s[w]              = valid_mem_r[rindex][w];
        look_dirty_s[w]              = dirty_mem_r[rindex][w];
      end
      match_s[w]  = look_valid_s[w] && (look_tag_s[w*s_tag +: s_tag] == rtag);
      match_cnt_s = match_cnt_s + {{s_way{1'b0}}, match_s[w]};
    end
    // Scan downward so the lowest matching way is the one that sticks.
    for (int w = ways - 1; w >= 0; w--) begin
      if (match_s[w]) begin
        hit_way_s = s_way'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
  end

  // Lookup result registers; they hold unless an accepted read occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit       <= 1'b0;
      hit_way   <= '0;
      multi_hit <= 1'b0;
      tag_out   <= '0;
      valid_out <= '0;
      dirty_out <= '0;
    end else if (do_read_s) begin
      hit       <= |match_s;
      hit_way   <= hit_way_s;
      multi_hit <= (match_cnt_s > (s_way + 1)'(1));
      tag_out   <= look_tag_s;
      valid_out <= look_valid_s;
      dirty_out <= look_dirty_s;
    end
  end

endmodule

// File: tb/tb_l2_tag_array.sv
// Self-checking bench for l2_tag_array: directed vector table, sweep/flush/reset
// sequences and randomized traffic against an array-based reference model.
module tb_l2_tag_array;

  localparam int SI = 3;
  localparam int ST = 23;
  localparam int W  = 4;
  localparam int SW = 2;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          ready;
  logic          read = 1'b0;
  logic [SI-1:0] rindex = '0;
  logic [ST-1:0] rtag = '0;
  logic          load = 1'b0;
  logic [SI-1:0] windex = '0;
  logic [SW-1:0] wway = '0;
  logic [ST-1:0] wtag = '0;
  logic          wvalid = 1'b0;
  logic          wdirty = 1'b0;
  logic          hit;
  logic [SW-1:0] hit_way;
  logic          multi_hit;
  logic [W*ST-1:0] tag_out;
  logic [W-1:0]  valid_out;
  logic [W-1:0]  dirty_out;

  l2_tag_array #(.s_index(SI), .s_tag(ST), .ways(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready),
    .read(read), .rindex(rindex), .rtag(rtag),
    .load(load), .windex(windex), .wway(wway), .wtag(wtag),
    .wvalid(wvalid), .wdirty(wdirty),
    .hit(hit), .hit_way(hit_way), .multi_hit(multi_hit),
    .tag_out(tag_out), .valid_out(valid_out), .dirty_out(dirty_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays plus a countdown of remaining sweep cycles.
  logic [ST-1:0] m_tag [NS][W];
  logic          m_v   [NS][W];
  logic          m_d   [NS][W];
  int            m_busy = 0;
  logic          e_hit;
  logic [SW-1:0] e_way;
  logic          e_multi;
  logic [W*ST-1:0] e_tag;
  logic [W-1:0]  e_v, e_d;

  typedef struct {
    logic rd; logic [SI-1:0] ri; logic [ST-1:0] rt;
    logic ld; logic [SI-1:0] wi; logic [SW-1:0] ww; logic [ST-1:0] wt;
    logic wv; logic wd; logic chk;
    logic x_hit; logic [SW-1:0] x_way; logic x_multi;
    logic [W-1:0] x_v; logic [W-1:0] x_d; logic [ST-1:0] x_t1;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ready"},     ready,     (m_busy == 0));
    check({tag, ".hit"},       hit,       e_hit);
    check({tag, ".hit_way"},   hit_way,   e_way);
    check({tag, ".multi_hit"}, multi_hit, e_multi);
    check({tag, ".tag_out"},   tag_out,   e_tag);
    check({tag, ".valid_out"}, valid_out, e_v);
    check({tag, ".dirty_out"}, dirty_out, e_d);
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < W; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
  endtask

  task automatic cycle(input logic rd, input logic [SI-1:0] ri, input logic [ST-1:0] rt,
                       input logic ld, input logic [SI-1:0] wi, input logic [SW-1:0] ww,
                       input logic [ST-1:0] wt, input logic wv, input logic wd,
                       input logic fl, input string tag);
    int n;
    logic [ST-1:0] t;
    logic v, d;
    read = rd; rindex = ri; rtag = rt;
    load = ld; windex = wi; wway = ww; wtag = wt; wvalid = wv; wdirty = wd;
    flush = fl;
    if (m_busy > 0) begin
      m_busy--;
    end else if (fl) begin
      m_busy = NS;
      model_clear();
    end else begin
      if (rd) begin
        n = 0;
        e_way = '0;
        for (int w = 0; w < W; w++) begin
          if (ld && wi == ri && int'(ww) == w) begin
            t = wt; v = wv; d = wd;
          end else begin
            t = m_tag[ri][w]; v = m_v[ri][w]; d = m_d[ri][w];
          end
          e_tag[w*ST +: ST] = t;
          e_v[w] = v;
          e_d[w] = d;
          if (v && t == rt) begin
            if (n == 0) e_way = SW'(w);
            n++;
          end
        end
        e_hit = (n > 0);
        e_multi = (n > 1);
      end
      if (ld) begin
        m_tag[wi][ww] = wt;
        m_v[wi][ww] = wv;
        m_d[wi][ww] = wd;
      end
    end
    step();
    read = 1'b0; load = 1'b0; flush = 1'b0;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; read = 1'b0; load = 1'b0; flush = 1'b0;
    repeat (n) step();
    rst = 1'b0;
    m_busy = NS;
    model_clear();
    e_hit = 1'b0; e_way = '0; e_multi = 1'b0; e_tag = '0; e_v = '0; e_d = '0;
    check_model("reset");
  endtask

  // Count cycles with ready low, bounded so a stuck sweep still ends the run.
  task automatic count_low(input string tag);
    int c;
    c = 0;
    while (!ready && c < 40) begin
      c++;
      idle(tag);
    end
    check({tag, ".ready_low_cycles"}, c, NS);
  endtask

  initial begin
    logic snap_hit;
    logic [SW-1:0] snap_way;
    logic [SI-1:0] ri, wi;

    vecs[0] = '{1'b0, 3'd0, 23'h0,     1'b1, 3'd2, 2'd3, 23'h1ABCD, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 23'h0};
    vecs[1] = '{1'b1, 3'd2, 23'h1ABCD, 1'b0, 3'd0, 2'd0, 23'h0,     1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000, 4'b1000, 23'h0};
    vecs[2] = '{1'b1, 3'd4, 23'h55,    1'b1, 3'd4, 2'd1, 23'h55,    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000, 23'h55};
    vecs[3] = '{1'b1, 3'd4, 23'h66,    1'b1, 3'd3, 2'd1, 23'h66,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 23'h55};
    vecs[4] = '{1'b0, 3'd0, 23'h0,     1'b1, 3'd4, 2'd1, 23'h55,    1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 23'h0};
    vecs[5] = '{1'b1, 3'd4, 23'h55,    1'b0, 3'd0, 2'd0, 23'h0,     1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 23'h55};
    vecs[6] = '{1'b0, 3'd0, 23'h0,     1'b1, 3'd6, 2'd0, 23'h7,     1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 23'h0};
    vecs[7] = '{1'b0, 3'd0, 23'h0,     1'b1, 3'd6, 2'd2, 23'h7,     1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 23'h0};
    vecs[8] = '{1'b1, 3'd6, 23'h7,     1'b0, 3'd0, 2'd0, 23'h0,     1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0101, 4'b0000, 23'h0};

    // Reset: two cycles held, then exactly NS cycles with ready low.
    do_reset(2);
    count_low("post_reset");

    // Give every tag a known value so tag_out is fully predictable.
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < W; w++)
        cycle(1'b0, '0, '0, 1'b1, SI'(s), SW'(w), '0, 1'b0, 1'b0, 1'b0, "init");

    cycle(1'b1, 3'd5, 23'h12345, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, "read_set5");
    check("read_set5.hit", hit, 1'b0);
    check("read_set5.valid_out", valid_out, 4'b0000);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].rd, vecs[i].ri, vecs[i].rt, vecs[i].ld, vecs[i].wi, vecs[i].ww,
            vecs[i].wt, vecs[i].wv, vecs[i].wd, 1'b0, $sformatf("vec%0d", i));
      if (vecs[i].chk) begin
        check($sformatf("vec%0d.hit", i), hit, vecs[i].x_hit);
        check($sformatf("vec%0d.hit_way", i), hit_way, vecs[i].x_way);
        check($sformatf("vec%0d.multi_hit", i), multi_hit, vecs[i].x_multi);
        check($sformatf("vec%0d.valid_out", i), valid_out, vecs[i].x_v);
        check($sformatf("vec%0d.dirty_out", i), dirty_out, vecs[i].x_d);
        check($sformatf("vec%0d.tag_way1", i), tag_out[1*ST +: ST], vecs[i].x_t1);
      end
    end

    // Flush mid-traffic with a simultaneous load that must be dropped.
    cycle(1'b0, '0, '0, 1'b1, 3'd0, 2'd0, 23'h11, 1'b1, 1'b1, 1'b0, "fill0");
    cycle(1'b0, '0, '0, 1'b1, 3'd7, 2'd3, 23'h22, 1'b1, 1'b0, 1'b0, "fill7");
    cycle(1'b1, 3'd7, 23'h22, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, "pre_flush_read");
    check("pre_flush.hit", hit, 1'b1);
    check("pre_flush.hit_way", hit_way, 2'd3);
    snap_hit = hit;
    snap_way = hit_way;
    cycle(1'b1, 3'd0, 23'h11, 1'b1, 3'd0, 2'd1, 23'h33, 1'b1, 1'b0, 1'b1, "flush");
    count_low("flush_sweep");
    check("flush.held_hit", hit, snap_hit);
    check("flush.held_hit_way", hit_way, snap_way);
    cycle(1'b1, 3'd0, 23'h11, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, "post_flush0");
    check("post_flush0.hit", hit, 1'b0);
    cycle(1'b1, 3'd7, 23'h22, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, "post_flush7");
    check("post_flush7.hit", hit, 1'b0);
    cycle(1'b1, 3'd0, 23'h33, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, "dropped_load");
    check("dropped_load.hit", hit, 1'b0);

    // Reset at sweep cycle 4 restarts the full sweep.
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, "flush2");
    repeat (4) idle("mid_sweep");
    do_reset(1);
    count_low("restart_sweep");

    // Randomized traffic with a small tag pool to provoke hits and multi-hits.
    for (int i = 0; i < 400; i++) begin
      ri = SI'($urandom_range(0, NS - 1));
      wi = ($urandom_range(0, 1) == 1) ? ri : SI'($urandom_range(0, NS - 1));
      cycle(1'($urandom_range(0, 1)), ri, ST'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), wi, SW'($urandom_range(0, W - 1)),
            ST'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
